// File: rtl/img_wr_pkg.sv
// Shared types and helpers for the image RAM pixel writer.
// Build option: IMG_WR_BYTE_SWAP_EN selects big-endian lane packing.
package img_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOP,
    CAPTURE,
    DRAIN,
    DONE
  } wr_state_e;

  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned PIX_W        = 8;
  localparam int unsigned WORD_W       = PIX_PER_WORD * PIX_W;

  function automatic logic [1:0] lane_to_byte(input logic [1:0] lane);
`ifdef IMG_WR_BYTE_SWAP_EN
    return 2'd3 - lane;
`else
    return lane;
`endif
  endfunction

endpackage

// File: rtl/img_wr_packer.sv
// Packs 8-bit pixels into 32-bit words with per-lane byte enables.
// Emits a registered word one cycle after the completing pixel.
module img_wr_packer
  import img_wr_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_clear,
  input  logic                    i_push,
  input  logic                    i_flush,
  input  logic [PIX_W-1:0]        i_data,
  output logic [1:0]              o_lane,
  output logic                    o_word_valid,
  output logic [WORD_W-1:0]       o_word,
  output logic [PIX_PER_WORD-1:0] o_be
);

  logic [1:0]              r_lane;
  logic [WORD_W-1:0]       r_acc;
  logic [PIX_PER_WORD-1:0] r_acc_be;
  logic                    r_word_valid;
  logic [WORD_W-1:0]       r_word;
  logic [PIX_PER_WORD-1:0] r_be;

  logic [1:0]              w_lane;
  logic [1:0]              w_byte;
  logic [WORD_W-1:0]       w_acc;
  logic [PIX_PER_WORD-1:0] w_be;
  logic                    w_emit;

  // Clear discards any partial word so the same-cycle pixel lands in lane 0.
  always_comb begin
    w_lane = i_clear ? '0 : r_lane;
    w_byte = lane_to_byte(w_lane);
    w_acc  = i_clear ? '0 : r_acc;
    w_acc[{w_byte, 3'b000} +: PIX_W] = i_data;
    w_be   = (i_clear ? '0 : r_acc_be) | (PIX_PER_WORD'(1) << w_byte);
    w_emit = i_push && ((w_lane == 2'd3) || i_flush);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lane       <= '0;
      r_acc        <= '0;
      r_acc_be     <= '0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
      r_be         <= '0;
    end else begin
      r_word_valid <= w_emit;
      if (w_emit) begin
        r_word <= w_acc;
        r_be   <= w_be;
      end
      if (i_push) begin
        if (w_emit) begin
          r_lane   <= '0;
          r_acc    <= '0;
          r_acc_be <= '0;
        end else begin
          r_lane   <= w_lane + 2'd1;
          r_acc    <= w_acc;
          r_acc_be <= w_be;
        end
      end else if (i_clear) begin
        r_lane   <= '0;
        r_acc    <= '0;
        r_acc_be <= '0;
      end
    end
  end

  assign o_lane       = r_lane;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;
  assign o_be         = r_be;

endmodule

// File: rtl/img_pixel_writer.sv
// Captures one framed pixel stream into the dual-port image RAM via port 2.
// Build option: IMG_WR_BYTE_SWAP_EN (see img_wr_pkg) for big-endian packing.
module img_pixel_writer
  import img_wr_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WORDS  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              arm,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  output logic              mem_clken,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              resync,
  output logic [ADDR_W:0]   words_written
);

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(WORDS - 1);

  wr_state_e       r_state, w_state_next;
  logic [ADDR_W:0] r_addr;
  logic            r_done, r_busy, r_overflow, r_resync;

  logic            w_accept, w_push, w_clear, w_flush, w_restart;
  logic            w_ovf_set, w_resync_set, w_word_valid, w_last_word;
  logic [1:0]      w_lane;

  assign in_ready    = (r_state == WAIT_SOP) || (r_state == CAPTURE) || (r_state == DRAIN);
  assign w_accept    = in_valid && in_ready;
  assign w_last_word = (r_addr == LAST_ADDR) && (w_lane == 2'd3);

  // arm and a sop pixel share the restart path; arm only suppresses resync.
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_clear      = 1'b0;
    w_flush      = 1'b0;
    w_restart    = 1'b0;
    w_ovf_set    = 1'b0;
    w_resync_set = 1'b0;
    if (arm || (w_accept && in_sop)) begin
      w_clear      = 1'b1;
      w_restart    = 1'b1;
      w_state_next = WAIT_SOP;
      w_resync_set = !arm && (r_state != WAIT_SOP);
      if (w_accept && in_sop) begin
        w_push       = 1'b1;
        w_flush      = in_eop;
        w_state_next = in_eop ? DONE : CAPTURE;
      end
    end else if (w_accept) begin
      if (r_state == CAPTURE) begin
        w_push  = 1'b1;
        w_flush = in_eop;
        if (in_eop)           w_state_next = DONE;
        else if (w_last_word) w_state_next = DRAIN;
      end else if (r_state == DRAIN) begin
        w_ovf_set = 1'b1;
        if (in_eop) w_state_next = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_resync   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_restart)         r_addr <= '0;
      else if (w_word_valid) r_addr <= r_addr + 1'b1;
      r_done     <= !arm && (r_state == DONE);
      r_busy     <= arm || in_ready;
      r_overflow <= !arm && (r_overflow || w_ovf_set);
      r_resync   <= !arm && (r_resync || w_resync_set);
    end
  end

  img_wr_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_clear      (w_clear),
    .i_push       (w_push),
    .i_flush      (w_flush),
    .i_data       (in_data),
    .o_lane       (w_lane),
    .o_word_valid (w_word_valid),
    .o_word       (mem_writedata),
    .o_be         (mem_byteenable)
  );

  assign mem_address    = r_addr[ADDR_W-1:0];
  assign mem_write      = w_word_valid;
  assign mem_chipselect = w_word_valid;
  assign mem_clken      = 1'b1;
  assign busy           = r_busy;
  assign done           = r_done;
  assign overflow       = r_overflow;
  assign resync         = r_resync;
  assign words_written  = r_addr;

endmodule

// File: doc/img_pixel_writer.md
# img_pixel_writer

Upstream feeder for the dual-port image RAM: accepts an 8-bit pixel stream (valid/ready, start/end-of-frame), packs four pixels per 32-bit word and writes them through the RAM's second port (address2/byteenable2/chipselect2/write2/writedata2/clken2). One armed capture fills the RAM from word 0. Software on the first port reads the frame once `done` is set.

## Interface
- ADDR_W, 10, RAM word-address width
- WORDS, 1024, RAM depth in 32-bit words; last writable address WORDS-1
- clk  in  1  sole clock, shared with RAM port 2
- reset_n  in  1  asynchronous active-low reset
- arm  in  1  one-cycle pulse: start a new capture, clear status
- in_data  in  8  pixel
- in_valid  in  1  pixel valid
- in_sop  in  1  first pixel of frame, qualified by in_valid
- in_eop  in  1  last pixel of frame, qualified by in_valid
- in_ready  out  1  block accepts pixel this cycle
- mem_address  out  ADDR_W  word address to RAM port 2
- mem_byteenable  out  4  lanes written
- mem_chipselect  out  1  equals mem_write
- mem_write  out  1  one-cycle write strobe
- mem_writedata  out  32  packed word
- mem_clken  out  1  RAM port-2 clock enable, 1 after reset
- busy  out  1  capture in progress (WAIT_SOP, CAPTURE, DRAIN)
- done  out  1  frame complete, held until arm
- overflow  out  1  frame exceeded WORDS*4 pixels, held until arm
- resync  out  1  in_sop seen mid-frame, held until arm
- words_written  out  ADDR_W+1  words written this frame (0..WORDS)

## Operation
- Accept = in_valid & in_ready.
- States: IDLE -> (arm) WAIT_SOP -> (accept & in_sop) CAPTURE -> (accept & in_eop) DONE; CAPTURE -> (word WORDS-1 written, no eop) DRAIN -> (accept & in_eop) DONE; DONE -> (arm) WAIT_SOP. arm in any state restarts in WAIT_SOP with all status and counters cleared.
- in_ready: 0 in IDLE/DONE, 1 in WAIT_SOP/CAPTURE/DRAIN. In WAIT_SOP, pixels without in_sop are accepted and discarded.
- Packing: lane counter 0..3; pixel at lane i goes to byte i (bits 8i+7:8i); byteenable bit i set. The sop pixel is lane 0 of address 0.
- Write issued when lane 3 is filled or eop is accepted; partial word writes only filled lanes, unused bytes 0.
- Address increments after each write; words_written = address after last write.
- sop & eop on same pixel: single write, be 0x1, done.
- Mid-frame in_sop in CAPTURE/DRAIN: pending partial word discarded, lane and address reset to 0, pixel taken as lane 0, resync=1, state CAPTURE.
- Overflow: after the write to WORDS-1, further non-eop pixels set overflow and go to DRAIN; DRAIN accepts and drops until eop; no write ever exceeds WORDS-1. eop on the pixel completing word WORDS-1 is not overflow.

## Timing
- Reset: all outputs 0 except mem_clken=1; state IDLE.
- Write latency: mem_write high in cycle T+1 for the completing pixel accepted in T; one cycle wide; back-to-back words allowed every 4 accepts, in_ready never deasserts for write back-pressure (RAM has none).
- done rises in T+2 after eop accepted in T (after final write); busy falls the same cycle.
- arm in same cycle as accept: arm wins, pixel handled as in WAIT_SOP.
- reset_n low mid-frame: immediate return to reset values; partial word lost.

## Configuration
- IMG_WR_BYTE_SWAP_EN defined: pixel at lane i goes to byte 3-i, byteenable bit 3-i (big-endian packing). Undefined: little-endian as above.

## Structure
- Package img_wr_pkg: state enum (IDLE, WAIT_SOP, CAPTURE, DRAIN, DONE), PIX_PER_WORD=4, PIX_W=8, lane-to-byte function.
- Sub-module img_wr_packer: lane counter, byte accumulator, byteenable build, clear/flush inputs, word_valid output; FSM and address counter in top.

## Test plan
- arm, 8 pixels 0x01..0x08 with sop/eop -> writes addr0 0x04030201 be 0xF, addr1 0x08070605 be 0xF; done, words_written=2.
- 5 pixels 0x01..0x05 -> addr1 data 0x00000005 be 0x1; words_written=2.
- 4100-pixel frame -> 1024 full writes, last at addr 1023; overflow=1, no further mem_write; done after eop; words_written=1024.
- sop at pixel 6 of a frame -> resync=1, pixel 6 written at addr0 lane0, partial word discarded.
- reset_n low after 3 pixels -> all outputs reset value, no write; re-arm, 4 pixels -> addr0 full word.
- IMG_WR_BYTE_SWAP_EN, 4 pixels 0x01..0x04 -> addr0 0x01020304; 1 pixel -> be 0x8, data 0x01000000.
